// File: rtl/mul8_nibble_sched.sv
// Sequential 8x8 nibble-decomposed multiplier scheduler: one shared external 4x4 core, one partial product per cycle.
// Build option: define MUL8_ZERO_SKIP_EN to skip phases whose nibble pair contains a zero nibble.
module mul8_nibble_sched #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       a,
  input  logic [7:0]       b,
  output logic [3:0]       sub_a,
  output logic [3:0]       sub_b,
  output logic             sub_hh,
  input  logic [7:0]       sub_prod,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      prod8,
  output logic             busy,
  output logic [CNT_W-1:0] done_cnt
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_P_LL,
    S_P_LH,
    S_P_HL,
    S_P_HH,
    S_DONE
  } state_t;

  state_t           r_state;
  state_t           w_next_state;
  logic [7:0]       r_a;
  logic [7:0]       r_b;
  logic [15:0]      r_acc;
  logic [15:0]      r_prod;
  logic             r_out_valid;
  logic [CNT_W-1:0] r_done_cnt;

  logic [15:0]      w_addend;
  logic [15:0]      w_acc_sum;
  logic [3:0]       w_run_in;   // bit0 LL, bit1 LH, bit2 HL, bit3 HH
  logic [3:0]       w_run_reg;

`ifdef MUL8_ZERO_SKIP_EN
  assign w_run_in  = {(a[7:4] != 4'h0) && (b[7:4] != 4'h0),
                      (a[7:4] != 4'h0) && (b[3:0] != 4'h0),
                      (a[3:0] != 4'h0) && (b[7:4] != 4'h0),
                      (a[3:0] != 4'h0) && (b[3:0] != 4'h0)};
  assign w_run_reg = {(r_a[7:4] != 4'h0) && (r_b[7:4] != 4'h0),
                      (r_a[7:4] != 4'h0) && (r_b[3:0] != 4'h0),
                      (r_a[3:0] != 4'h0) && (r_b[7:4] != 4'h0),
                      (r_a[3:0] != 4'h0) && (r_b[3:0] != 4'h0)};
`else
  assign w_run_in  = 4'b1111;
  assign w_run_reg = 4'b1111;
`endif

  // First phase still to run among those flagged in run, in fixed LL->LH->HL->HH order.
  function automatic state_t first_phase(input logic [3:0] run);
    if (run[0])      first_phase = S_P_LL;
    else if (run[1]) first_phase = S_P_LH;
    else if (run[2]) first_phase = S_P_HL;
    else if (run[3]) first_phase = S_P_HH;
    else             first_phase = S_DONE;
  endfunction

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    w_next_state = r_state;
    sub_a        = 4'h0;
    sub_b        = 4'h0;
    sub_hh       = 1'b0;
    w_addend     = 16'h0000;
    unique case (r_state)
      S_IDLE: begin
        if (in_valid) w_next_state = first_phase(w_run_in);
      end
      S_P_LL: begin
        sub_a        = r_a[3:0];
        sub_b        = r_b[3:0];
        w_addend     = {8'h00, sub_prod};
        w_next_state = first_phase(w_run_reg & 4'b1110);
      end
      S_P_LH: begin
        sub_a        = r_a[3:0];
        sub_b        = r_b[7:4];
        w_addend     = {4'h0, sub_prod, 4'h0};
        w_next_state = first_phase(w_run_reg & 4'b1100);
      end
      S_P_HL: begin
        sub_a        = r_a[7:4];
        sub_b        = r_b[3:0];
        w_addend     = {4'h0, sub_prod, 4'h0};
        w_next_state = first_phase(w_run_reg & 4'b1000);
      end
      S_P_HH: begin
        sub_a        = r_a[7:4];
        sub_b        = r_b[7:4];
        sub_hh       = 1'b1;
        w_addend     = {sub_prod, 8'h00};
        w_next_state = S_DONE;
      end
      S_DONE: begin
        if (out_ready) w_next_state = S_IDLE;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  assign w_acc_sum = r_acc + w_addend;

  // NOTE: the operand registers are reset along with the control state so a restart never sees stale nibbles.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_a         <= 8'h00;
      r_b         <= 8'h00;
      r_acc       <= 16'h0000;
      r_prod      <= 16'h0000;
      r_out_valid <= 1'b0;
      r_done_cnt  <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      r_state <= w_next_state;
      unique case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_a   <= a;
            r_b   <= b;
            r_acc <= 16'h0000;
            if (w_next_state == S_DONE) begin
              r_prod      <= 16'h0000;
              r_out_valid <= 1'b1;
            end
          end
        end
        S_P_LL, S_P_LH, S_P_HL, S_P_HH: begin
          r_acc <= w_acc_sum;
          if (w_next_state == S_DONE) begin
            r_prod      <= w_acc_sum;
            r_out_valid <= 1'b1;
          end
        end
        S_DONE: begin
          if (r_out_valid && out_ready) begin
            r_out_valid <= 1'b0;
            r_done_cnt  <= r_done_cnt + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (r_state == S_IDLE);
  assign busy      = (r_state != S_IDLE);
  assign out_valid = r_out_valid;
  assign prod8     = r_prod;
  assign done_cnt  = r_done_cnt;

endmodule

// File: tb/tb_mul8_nibble_sched.sv
// Directed bench for mul8_nibble_sched with an exact 4x4 core stub (optionally forced to 0xFF).
// Zero-skip vectors are compiled in when MUL8_ZERO_SKIP_EN is defined.
module tb_mul8_nibble_sched;

  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [7:0]       a;
  logic [7:0]       b;
  logic [3:0]       sub_a;
  logic [3:0]       sub_b;
  logic             sub_hh;
  logic [7:0]       sub_prod;
  logic             out_valid;
  logic             out_ready;
  logic [15:0]      prod8;
  logic             busy;
  logic [CNT_W-1:0] done_cnt;
  logic             force_ff;

  int n_checks = 0;
  int n_errors = 0;

  mul8_nibble_sched #(.CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .sub_a     (sub_a),
    .sub_b     (sub_b),
    .sub_hh    (sub_hh),
    .sub_prod  (sub_prod),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .prod8     (prod8),
    .busy      (busy),
    .done_cnt  (done_cnt)
  );

  always #5 clk = ~clk;

  assign sub_prod = force_ff ? 8'hFF : ({4'h0, sub_a} * {4'h0, sub_b});

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Accept one operand pair, then count edges after the accepting edge until out_valid,
  // recording sub_hh and {sub_a,sub_b} for each phase cycle.
  task automatic do_op(input logic [7:0] op_a, input logic [7:0] op_b,
                       output int lat, output logic [3:0] hh, output logic [31:0] seq);
    int w;
    @(negedge clk);
    in_valid = 1'b1;
    a        = op_a;
    b        = op_b;
    w = 0;
    while (!in_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    @(negedge clk);
    in_valid = 1'b0;
    lat = 0;
    hh  = 4'b0000;
    seq = 32'h0;
    while (!out_valid && lat < 20) begin
      if (lat < 4) hh[lat] = sub_hh;
      seq = (seq << 8) | {24'h0, sub_a, sub_b};
      @(negedge clk);
      lat++;
    end
  endtask

  // Hand-off happens on the edge after out_valid was seen with out_ready high.
  task automatic finish_op(input string tag);
    @(negedge clk);
    check({tag, "_ov_after"}, out_valid, 1'b0);
    check({tag, "_idle_after"}, in_ready, 1'b1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  int          lat;
  logic [3:0]  hh;
  logic [31:0] seq;
  logic [15:0] held;
  int          bad;
  logic [7:0]  va [3];
  logic [7:0]  vb [3];
  logic [15:0] ve [3];
  logic [15:0] got_p [3];
  int          acc_cyc [3];
  int          k_in;
  int          k_out;

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    a         = 8'h00;
    b         = 8'h00;
    out_ready = 1'b1;
    force_ff  = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_prod8", prod8, 16'h0000);
    check("rst_done_cnt", done_cnt, 16'h0000);
    check("rst_sub", {sub_a, sub_b, sub_hh}, 9'h000);
    rst = 1'b0;

`ifndef MUL8_ZERO_SKIP_EN
    // 0x12 * 0x34 = 0x03A8; phases see (2,4) (2,3) (1,4) (1,3)
    do_op(8'h12, 8'h34, lat, hh, seq);
    check("op1_latency", lat, 4);
    check("op1_sub_hh", hh, 4'b1000);
    check("op1_nibbles", seq, 32'h24231413);
    check("op1_prod8", prod8, 16'h03A8);
    finish_op("op1");
    check("op1_done_cnt", done_cnt, 16'd1);

    do_op(8'hFF, 8'hFF, lat, hh, seq);
    check("ff_prod8", prod8, 16'hFE01);
    finish_op("ff");

    // 0xFF + 0xFF0 + 0xFF0 + 0xFF00 = 0x11FDF -> 0x1FDF modulo 2^16
    force_ff = 1'b1;
    do_op(8'hFF, 8'hFF, lat, hh, seq);
    check("wrap_prod8", prod8, 16'h1FDF);
    finish_op("wrap");
    force_ff = 1'b0;
    check("wrap_done_cnt", done_cnt, 16'd3);

    // Backpressure: sink stalls 10 cycles while the source keeps offering new operands.
    out_ready = 1'b0;
    do_op(8'h0B, 8'h0D, lat, hh, seq);
    check("bp_latency", lat, 4);
    check("bp_prod8", prod8, 16'h008F);
    held = prod8;
    bad  = 0;
    in_valid = 1'b1;
    a = 8'h77;
    b = 8'h66;
    for (int i = 0; i < 10; i++) begin
      if (prod8 !== held || out_valid !== 1'b1 || in_ready !== 1'b0 || busy !== 1'b1) bad++;
      @(negedge clk);
    end
    check("bp_stable_cycles_bad", bad, 0);
    check("bp_done_cnt_held", done_cnt, 16'd3);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    finish_op("bp");
    check("bp_done_cnt", done_cnt, 16'd4);
    check("bp_prod8_kept", prod8, 16'h008F);

    // Reset while in P_HL discards the in-flight product.
    @(negedge clk);
    in_valid = 1'b1;
    a = 8'h12;
    b = 8'h34;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("mid_hl_nibbles", {sub_a, sub_b, sub_hh}, 9'h028);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_idle", in_ready, 1'b1);
    check("mid_rst_out_valid", out_valid, 1'b0);
    check("mid_rst_prod8", prod8, 16'h0000);
    check("mid_rst_done_cnt", done_cnt, 16'd0);
    do_op(8'h03, 8'h05, lat, hh, seq);
    check("post_rst_prod8", prod8, 16'h000F);
    finish_op("post_rst");

    // Back-to-back with in_valid held high.
    do_reset();
    va = '{8'h10, 8'h0F, 8'hA5};
    vb = '{8'h10, 8'h0F, 8'h5A};
    ve = '{16'h0100, 16'h00E1, 16'h3A02};
    k_in  = 0;
    k_out = 0;
    for (int cyc = 0; cyc < 100 && k_out < 3; cyc++) begin
      if (out_valid && out_ready) begin
        got_p[k_out] = prod8;
        k_out++;
      end
      if (k_in < 3) begin
        in_valid = 1'b1;
        a = va[k_in];
        b = vb[k_in];
        if (in_ready) begin
          acc_cyc[k_in] = cyc;
          k_in++;
        end
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    check("b2b_results_seen", k_out, 3);
    for (int i = 0; i < 3; i++) check($sformatf("b2b_prod8_%0d", i), got_p[i], ve[i]);
    check("b2b_gap01", acc_cyc[1] - acc_cyc[0], 6);
    check("b2b_gap12", acc_cyc[2] - acc_cyc[1], 6);
    check("b2b_done_cnt", done_cnt, 16'd3);
`else
    do_op(8'h05, 8'h07, lat, hh, seq);
    check("zs_ll_latency", lat, 1);
    check("zs_ll_sub_hh", hh, 4'b0000);
    check("zs_ll_prod8", prod8, 16'h0023);
    finish_op("zs_ll");

    // All phases skipped: DONE is reached on the accepting edge itself.
    do_op(8'h00, 8'h37, lat, hh, seq);
    check("zs_zero_latency", lat, 0);
    check("zs_zero_prod8", prod8, 16'h0000);
    finish_op("zs_zero");

    do_op(8'h50, 8'h03, lat, hh, seq);
    check("zs_hl_latency", lat, 1);
    check("zs_hl_nibbles", seq, 32'h00000053);
    check("zs_hl_prod8", prod8, 16'h00F0);
    finish_op("zs_hl");

    do_op(8'h12, 8'h34, lat, hh, seq);
    check("zs_full_latency", lat, 4);
    check("zs_full_sub_hh", hh, 4'b1000);
    check("zs_full_prod8", prod8, 16'h03A8);
    finish_op("zs_full");
    check("zs_done_cnt", done_cnt, 16'd4);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
